// File: rtl/multicycle_adder.sv
// Chunk-serial adder: WIDTH/CHUNK cycles per sum, with registered flags.
// MULTICYCLE_ADDER_SUB_EN adds a sub port for x - y - c_in with borrow-out.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c_in,
`ifdef MULTICYCLE_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int CK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int K  = (WIDTH / CK < 1) ? 1 : WIDTH / CK;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  generate
    if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CK) != 0) begin : g_bad
      $error("multicycle_adder: WIDTH must be a multiple of CHUNK >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] xa, ya;
  logic             cy;
  logic [IW-1:0]    idx;
  logic             sub_r;
  logic             sub_eff;
  logic             accept;
  logic             last;
  logic [CHUNK-1:0] xc, yc;
  logic [CHUNK:0]   sum;

`ifdef MULTICYCLE_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign accept = start && (state != RUN);
  assign last   = (idx == IW'(K - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    xc = '0;
    yc = '0;
    for (int k = 0; k < K; k++) begin
      if (idx == IW'(k)) begin
        xc = xa[k*CHUNK +: CHUNK];
        yc = ya[k*CHUNK +: CHUNK];
      end
    end
    sum = {1'b0, xc} + {1'b0, yc} + {{CHUNK{1'b0}}, cy};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is folded in at capture: y is inverted and the carry-in
  // complemented, so the run loop only ever adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xa    <= '0;
      ya    <= '0;
      cy    <= 1'b0;
      idx   <= '0;
      sub_r <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
      v     <= 1'b0;
    end else if (accept) begin
      xa    <= x;
      ya    <= sub_eff ? ~y : y;
      cy    <= sub_eff ? ~c_in : c_in;
      sub_r <= sub_eff;
      idx   <= '0;
      s     <= '0;
      c_out <= 1'b0;
      v     <= 1'b0;
    end else if (state == RUN) begin
      for (int k = 0; k < K; k++) begin
        if (idx == IW'(k)) s[k*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
      end
      cy  <= sum[CHUNK];
      idx <= idx + IW'(1);
      if (last) begin
        c_out <= sum[CHUNK] ^ sub_r;
        v     <= (xa[WIDTH-1] == ya[WIDTH-1]) &&
                 (sum[CHUNK-1] != xa[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder (WIDTH=16, CHUNK=4).
// Driver pushes modelled results; a negedge monitor checks each done.
module tb_multicycle_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int K = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [W-1:0] s;
  logic         c_out, v, busy, done;

  multicycle_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .c_in  (c_in),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .sub   (sub),
`endif
    .x     (x),
    .y     (y),
    .s     (s),
    .c_out (c_out),
    .v     (v),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   nt = 0;
  int   nf = 0;
  int   cyc = 0;
  int   bcnt = 0;
  int   last_done = 0;
  bit   hold_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    nt++;
    if (got !== want) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want,
               $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sm,
                                 input int when);
    exp_t r;
    logic [W:0] t;
    if (sm) begin
      t   = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
      r.s = t[W-1:0];
      r.c = (int'(a) < int'(b) + int'(ci));
      r.v = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
    end else begin
      t   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      r.s = t[W-1:0];
      r.c = t[W];
      r.v = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    end
    r.cyc = when;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("s", 32'(s), 32'(e.s));
        chk("c_out", 32'(c_out), 32'(e.c));
        chk("v", 32'(v), 32'(e.v));
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("busy_len", 32'(bcnt), 32'(K));
        if (hold_chk && last_done > 0)
          chk("done_gap", 32'(cyc - last_done), 32'(K + 1));
        last_done = cyc;
      end
      bcnt = 0;
    end else if (busy) begin
      bcnt++;
    end else begin
      bcnt = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sm, input bit hold);
    int w = 0;
    while (busy && w < 20) begin
      x     = W'($urandom);
      y     = W'($urandom);
      c_in  = 1'($urandom);
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      w++;
    end
    if (busy) chk("accept_timeout", 32'd1, 32'd0);
    x     = a;
    y     = b;
    c_in  = ci;
    sub   = sm;
    start = 1'b1;
    sb.push_back(model(a, b, ci, sm, cyc + 1 + K));
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  function automatic logic rnd_sub();
`ifdef MULTICYCLE_ADDER_SUB_EN
    return 1'($urandom);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int w;
    repeat (2) @(negedge clk);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_v", 32'(v), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
`ifdef MULTICYCLE_ADDER_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    issue(16'h0000, 16'h0000, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), rnd_sub(), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    w = 0;
    while (sb.size() > 0 && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    hold_chk  = 1;
    last_done = 0;
    for (int i = 0; i < 10; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), rnd_sub(), 1);
    start = 1'b0;
    w = 0;
    while (sb.size() > 0 && w < 50) begin @(negedge clk); w++; end
    hold_chk = 0;
    @(negedge clk);

    issue(16'hABCD, 16'h1357, 1'b1, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    chk("abort_v", 32'(v), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 10; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), rnd_sub(), 0);

    w = 0;
    while (sb.size() > 0 && w < 50) begin @(negedge clk); w++; end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
